// File: rtl/fp_multiplier_if.sv
// Start/ack/done handshake bundle for fp_multiplier.
// W must equal 1 + EXP_W + MAN_W of the attached multiplier.
interface fp_multiplier_if #(
  parameter int W = 16
) ();
  logic         start;
  logic [W-1:0] input_a;
  logic [W-1:0] input_b;
  logic         ack;
  logic         done;
  logic [W-1:0] output_z;
  logic [3:0]   flags;

  modport master (
    output start, input_a, input_b,
    input  ack, done, output_z, flags
  );

  modport slave (
    input  start, input_a, input_b,
    output ack, done, output_z, flags
  );
endinterface

// File: rtl/fp_multiplier.sv
// Six-state IEEE-754-style multiplier: round-to-nearest-even, zero/inf/NaN handling, flags.
// Define FP_MUL_DENORM_EN for gradual underflow; the default build flushes subnormals to zero.
module fp_multiplier #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic           clk,
  input  logic           reset,
  fp_multiplier_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam int LW = $clog2(PW + 1);
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ONE  = EW'(1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_MULT   = 3'd2;
  localparam logic [2:0] S_NORM   = 3'd3;
  localparam logic [2:0] S_ROUND  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // {nan, inf, zero} classification of one operand
  function automatic logic [2:0] classify(input logic [W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e = x[W-2 -: EXP_W];
    f = x[MAN_W-1:0];
    classify[2] = (&e) & (|f);
    classify[1] = (&e) & ~(|f);
`ifdef FP_MUL_DENORM_EN
    classify[0] = ~(|e) & ~(|f);
`else
    classify[0] = ~(|e);
`endif
  endfunction

  // {effective exponent, significand}; subnormals use exponent 1 and no hidden bit
  function automatic logic [EXP_W+MAN_W:0] unpack_sig(input logic [W-1:0] x);
    if (|x[W-2 -: EXP_W]) begin
      unpack_sig = {x[W-2 -: EXP_W], 1'b1, x[MAN_W-1:0]};
    end else begin
      unpack_sig = {{(EXP_W-1){1'b0}}, 1'b1, 1'b0, x[MAN_W-1:0]};
    end
  endfunction

`ifdef FP_MUL_DENORM_EN
  function automatic logic [LW-1:0] lead_zeros(input logic [PW-1:0] v);
    lead_zeros = LW'(PW);
    for (int i = 0; i < PW; i++) begin
      if (v[i]) lead_zeros = LW'(PW - 1 - i);
    end
  endfunction
`endif

  logic [2:0]              state_q, state_d;
  logic [W-1:0]            a_q, a_d, b_q, b_d;
  logic                    sign_q, sign_d, nan_q, nan_d, inf_q, inf_d, zero_q, zero_d;
  logic [EXP_W-1:0]        ea_q, ea_d, eb_q, eb_d;
  logic [MAN_W:0]          ma_q, ma_d, mb_q, mb_d;
  logic [PW-1:0]           sig_q, sig_d;
  logic signed [EW-1:0]    exp_q, exp_d;
  logic                    sticky_q, sticky_d;
  logic [W-1:0]            res_q, res_d, z_q, z_d;
  logic [3:0]              rflags_q, rflags_d, flags_q, flags_d;
  logic                    ack_q, ack_d, done_q, done_d;
`ifdef FP_MUL_DENORM_EN
  logic                    tiny_q, tiny_d;
  logic [EW-1:0]           rsh_s;
`endif

  logic [LW-1:0]           lz_s;
  logic [PW-1:0]           shifted_s;
  logic signed [EW-1:0]    nexp_s, rexp_s;
  logic [MAN_W:0]          kept_s;
  logic [MAN_W+1:0]        mant_s;
  logic                    guard_s, rnd_s, stk_s, inexact_s;

  // Normalisation (from the raw product) and rounding (from the normalised significand)
  always_comb begin
`ifdef FP_MUL_DENORM_EN
    lz_s = lead_zeros(sig_q);
`else
    lz_s = sig_q[PW-1] ? LW'(0) : LW'(1);
`endif
    shifted_s = sig_q << lz_s;
    nexp_s    = exp_q + ONE - $signed(EW'(lz_s));
`ifdef FP_MUL_DENORM_EN
    rsh_s     = ONE - nexp_s;
`endif
    kept_s    = sig_q[PW-1 -: MAN_W+1];
    guard_s   = sig_q[PW-2-MAN_W];
    rnd_s     = sig_q[PW-3-MAN_W];
    stk_s     = (|sig_q[PW-4-MAN_W:0]) | sticky_q;
    inexact_s = guard_s | rnd_s | stk_s;
    mant_s    = {1'b0, kept_s} + {{(MAN_W+1){1'b0}}, guard_s & (rnd_s | stk_s | kept_s[0])};
    if (mant_s[MAN_W+1]) begin
      mant_s = {1'b0, mant_s[MAN_W+1:1]};
      rexp_s = exp_q + ONE;
    end
`ifdef FP_MUL_DENORM_EN
    // a subnormal that rounds up into the hidden bit becomes the smallest normal
    else if (exp_q == '0 && mant_s[MAN_W]) begin
      rexp_s = ONE;
    end
`endif
    else begin
      rexp_s = exp_q;
    end
  end

  // FSM sequencing and per-state datapath register updates
  always_comb begin
    state_d = state_q;  a_d = a_q;  b_d = b_q;
    sign_d = sign_q;  nan_d = nan_q;  inf_d = inf_q;  zero_d = zero_q;
    ea_d = ea_q;  eb_d = eb_q;  ma_d = ma_q;  mb_d = mb_q;
    sig_d = sig_q;  exp_d = exp_q;  sticky_d = sticky_q;
    res_d = res_q;  rflags_d = rflags_q;  z_d = z_q;  flags_d = flags_q;
    ack_d = 1'b0;  done_d = 1'b0;
`ifdef FP_MUL_DENORM_EN
    tiny_d = tiny_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_UNPACK;
          a_d     = bus.input_a;
          b_d     = bus.input_b;
          ack_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_UNPACK: begin
        state_d                 = S_MULT;
        sign_d                  = a_q[W-1] ^ b_q[W-1];
        {nan_d, inf_d, zero_d}  = classify(a_q) | classify(b_q);
        {ea_d, ma_d}            = unpack_sig(a_q);
        {eb_d, mb_d}            = unpack_sig(b_q);
      end
      S_MULT: begin
        state_d = S_NORM;
        sig_d   = PW'(ma_q) * PW'(mb_q);
        exp_d   = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - BIAS;
      end
      S_NORM: begin
        state_d  = S_ROUND;
        sig_d    = shifted_s;
        exp_d    = nexp_s;
        sticky_d = 1'b0;
`ifdef FP_MUL_DENORM_EN
        if (nexp_s < ONE) begin
          tiny_d = 1'b1;
          exp_d  = '0;
          if (rsh_s > EW'(PW)) begin
            sig_d    = '0;
            sticky_d = |shifted_s;
          end else begin
            sig_d    = shifted_s >> rsh_s;
            sticky_d = |(shifted_s & ~({PW{1'b1}} << rsh_s));
          end
        end else begin
          tiny_d = 1'b0;
        end
`endif
      end
      S_ROUND: begin
        state_d = S_DONE;
        if (nan_q || (inf_q && zero_q)) begin
          res_d = QNAN;  rflags_d = 4'b1000;
        end else if (inf_q) begin
          res_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};  rflags_d = 4'b0000;
        end else if (zero_q) begin
          res_d = {sign_q, {(W-1){1'b0}}};  rflags_d = 4'b0000;
        end else if (rexp_s >= EMAX) begin
          res_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};  rflags_d = 4'b0101;
        end
`ifdef FP_MUL_DENORM_EN
        else begin
          res_d    = {sign_q, rexp_s[EXP_W-1:0], mant_s[MAN_W-1:0]};
          rflags_d = {2'b00, tiny_q & inexact_s, inexact_s};
        end
`else
        else if (rexp_s < ONE) begin
          res_d = {sign_q, {(W-1){1'b0}}};  rflags_d = 4'b0011;
        end else begin
          res_d    = {sign_q, rexp_s[EXP_W-1:0], mant_s[MAN_W-1:0]};
          rflags_d = {3'b000, inexact_s};
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        z_d     = res_q;
        flags_d = rflags_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;  a_q <= '0;  b_q <= '0;
      sign_q <= 1'b0;  nan_q <= 1'b0;  inf_q <= 1'b0;  zero_q <= 1'b0;
      ea_q <= '0;  eb_q <= '0;  ma_q <= '0;  mb_q <= '0;
      sig_q <= '0;  exp_q <= '0;  sticky_q <= 1'b0;
      res_q <= '0;  rflags_q <= 4'b0000;  z_q <= '0;  flags_q <= 4'b0000;
      ack_q <= 1'b0;  done_q <= 1'b0;
`ifdef FP_MUL_DENORM_EN
      tiny_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;  a_q <= a_d;  b_q <= b_d;
      sign_q <= sign_d;  nan_q <= nan_d;  inf_q <= inf_d;  zero_q <= zero_d;
      ea_q <= ea_d;  eb_q <= eb_d;  ma_q <= ma_d;  mb_q <= mb_d;
      sig_q <= sig_d;  exp_q <= exp_d;  sticky_q <= sticky_d;
      res_q <= res_d;  rflags_q <= rflags_d;  z_q <= z_d;  flags_q <= flags_d;
      ack_q <= ack_d;  done_q <= done_d;
`ifdef FP_MUL_DENORM_EN
      tiny_q <= tiny_d;
`endif
    end
  end

  assign bus.ack      = ack_q;
  assign bus.done     = done_q;
  assign bus.output_z = z_q;
  assign bus.flags    = flags_q;
endmodule

// File: tb/tb_fp_multiplier.sv
// Scoreboard bench for fp_multiplier: half-precision directed vectors plus a single-precision instance.
module tb_fp_multiplier;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   ack_cyc   = -100;
  int   last_done = -1;
  bit   b2b = 1'b0;
  logic [19:0] q16[$];
  logic [35:0] q32[$];

  fp_multiplier_if #(.W(16)) bus  ();
  fp_multiplier_if #(.W(32)) bus2 ();

  fp_multiplier #(.EXP_W(5), .MAN_W(10)) dut  (.clk(clk), .reset(reset), .bus(bus));
  fp_multiplier #(.EXP_W(8), .MAN_W(23)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // half-precision monitor: pops the scoreboard on every done
  initial begin : mon16
    logic [19:0] e;
    forever begin
      @(negedge clk);
      if (bus.ack) ack_cyc = cyc;
      if (bus.done) begin
        if (q16.size() == 0) begin
          check("unexpected_done16", 64'(bus.output_z), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = q16.pop_front();
          check("z16", 64'(bus.output_z), 64'(e[19:4]));
          check("flags16", 64'(bus.flags), 64'(e[3:0]));
          check("latency16", 64'(cyc - ack_cyc), 64'd5);
          if (b2b && last_done >= 0) check("b2b_spacing", 64'(cyc - last_done), 64'd6);
        end
        last_done = cyc;
      end
    end
  end

  initial begin : mon32
    logic [35:0] e;
    forever begin
      @(negedge clk);
      if (bus2.done) begin
        if (q32.size() == 0) begin
          check("unexpected_done32", 64'(bus2.output_z), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = q32.pop_front();
          check("z32", 64'(bus2.output_z), 64'(e[35:4]));
          check("flags32", 64'(bus2.flags), 64'(e[3:0]));
        end
      end
    end
  end

  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] z, input logic [3:0] f);
    int n;
    @(posedge clk); #1;
    bus.start = 1'b1;  bus.input_a = a;  bus.input_b = b;
    q16.push_back({z, f});
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.ack && n < 4);
    bus.start = 1'b0;
    check("ack_latency", 64'(n), 64'd2);
    @(negedge clk);
    check("ack_pulse", 64'(bus.ack), 64'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.done && n < 10);
    check("done_wait", 64'(n), 64'd4);
  endtask

  task automatic do_op32(input logic [99:0] v);
    int n;
    @(posedge clk); #1;
    bus2.start = 1'b1;  bus2.input_a = v[99:68];  bus2.input_b = v[67:36];
    q32.push_back(v[35:0]);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus2.ack && n < 4);
    bus2.start = 1'b0;
    check("ack32_latency", 64'(n), 64'd2);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus2.done && n < 10);
    check("done32_wait", 64'(n), 64'd5);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [51:0] vec [12];
    logic [99:0] v32 [3];
    int n;
    int acks;
    vec = '{
      {16'hBB33, 16'h0000, 16'h8000, 4'b0000},
      {16'hBB33, 16'hC333, 16'h427B, 4'b0001},
      {16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101},
      {16'h7C00, 16'h0000, 16'h7E00, 4'b1000},
      {16'h0400, 16'h3800, 16'h0000, 4'b0011},
      {16'h3C00, 16'h3C00, 16'h3C00, 4'b0000},
      {16'h7C00, 16'hC000, 16'hFC00, 4'b0000},
      {16'h7E00, 16'h3C00, 16'h7E00, 4'b1000},
      {16'h3C00, 16'h0001, 16'h0000, 4'b0000},
      {16'h8000, 16'hC000, 16'h0000, 4'b0000},
      {16'h3E00, 16'h3C01, 16'h3E02, 4'b0001},
      {16'h3E00, 16'h3C03, 16'h3E04, 4'b0001}
    };
`ifdef FP_MUL_DENORM_EN
    vec[4] = {16'h0400, 16'h3800, 16'h0200, 4'b0000};
    vec[8] = {16'h3C00, 16'h0001, 16'h0001, 4'b0000};
`endif
    v32 = '{
      {32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 4'b0000},
      {32'h3F80_0000, 32'hC000_0000, 32'hC000_0000, 4'b0000},
      {32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000}
    };
    bus.start = 1'b0;  bus.input_a = 16'h0000;  bus.input_b = 16'h0000;
    bus2.start = 1'b0; bus2.input_a = 32'h0;    bus2.input_b = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 64'(bus.ack), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_z", 64'(bus.output_z), 64'd0);
    check("rst_flags", 64'(bus.flags), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 12; i++) do_op(vec[i][51:36], vec[i][35:20], vec[i][19:4], vec[i][3:0]);

    // start held high: one accept every six clocks
    for (int i = 0; i < 4; i++) q16.push_back({16'h3C00, 4'b0000});
    last_done = -1;
    b2b = 1'b1;
    acks = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;  bus.input_a = 16'h3C00;  bus.input_b = 16'h3C00;
    repeat (20) begin
      @(negedge clk);
      if (bus.ack) acks++;
      @(posedge clk);
    end
    #1 bus.start = 1'b0;
    n = 0;
    while (q16.size() != 0 && n < 20) begin @(negedge clk); n++; end
    b2b = 1'b0;
    check("b2b_acks", 64'(acks), 64'd4);

    // reset two clocks into an operation
    @(posedge clk); #1;
    bus.start = 1'b1;  bus.input_a = 16'hBB33;  bus.input_b = 16'hC333;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.ack && n < 4);
    bus.start = 1'b0;
    check("abort_ack", 64'(n), 64'd2);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_ack_clr", 64'(bus.ack), 64'd0);
    check("abort_done_clr", 64'(bus.done), 64'd0);
    check("abort_z_clr", 64'(bus.output_z), 64'd0);
    check("abort_flags_clr", 64'(bus.flags), 64'd0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    repeat (10) @(negedge clk);
    do_op(16'hBB33, 16'hC333, 16'h427B, 4'b0001);

    for (int i = 0; i < 3; i++) do_op32(v32[i]);

    repeat (3) @(negedge clk);
    check("sb16_empty", 64'(q16.size()), 64'd0);
    check("sb32_empty", 64'(q32.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
